// File: rtl/trig_lut_arbiter.sv
// trig_lut_arbiter
//   Shares one synchronous sin/cos ROM among N_REQ requesters (tanks and
//   bullet engines). A round-robin FSM (IDLE -> ADDR -> DATA) issues one
//   lookup at a time. Each requester gets its result in its own holding
//   register, plus a one-cycle done pulse.
//
//   Optional feature macro: TRIG_ARB_CACHE_EN
//     When defined, each requester remembers the last legal angle it looked
//     up. A repeat request for that angle is answered from the held result
//     in one cycle, without touching the ROM.
//
// Ports
//   Clk, Reset       clock; asynchronous active-high reset
//   req[N]           level request per requester, held until its own done
//   angle_in[N*6]    packed angle index, slice i = [6i+5:6i]
//   done[N]          one-cycle pulse: result for requester i is valid
//   err[N]           last completed lookup of requester i had angle > ANG_MAX
//   sin_out/cos_out  packed 8-bit results per requester, held until next done
//   rom_rd/rom_addr  ROM read strobe and address
//   rom_sin/rom_cos  ROM data, valid the cycle after rom_rd
//   busy             FSM is not IDLE
module trig_lut_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ANG_W   = 6,
  parameter int ANG_MAX = 44
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ANG_W-1:0] angle_in,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic [N_REQ*8-1:0]     sin_out,
  output logic [N_REQ*8-1:0]     cos_out,
  output logic                   rom_rd,
  output logic [ANG_W-1:0]       rom_addr,
  input  logic [7:0]             rom_sin,
  input  logic [7:0]             rom_cos,
  output logic                   busy
);
  localparam int GW = $clog2(N_REQ);
  localparam logic [ANG_W-1:0] AMAX = ANG_W'(ANG_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                     state, state_nx;
  logic [GW-1:0]              rr, rr_nx, g, g_nx;
  logic                       eflag, eflag_nx;
  logic [ANG_W-1:0]           addr_nx;
  logic                       rd_nx, busy_nx;
  logic [N_REQ-1:0]           done_nx, err_nx;
  logic [N_REQ-1:0][7:0]      sin_q, cos_q, sin_nx, cos_nx;

  logic [N_REQ-1:0]           elig;
  logic                       found;
  logic [GW-1:0]              win;
  logic [ANG_W-1:0]           ang;
  logic                       bad;

`ifdef TRIG_ARB_CACHE_EN
  logic [N_REQ-1:0]             cv, cv_nx;
  logic [N_REQ-1:0][ANG_W-1:0]  ca, ca_nx;
`endif

  assign sin_out = sin_q;
  assign cos_out = cos_q;

  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] x);
    return (int'(x) == N_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rr       <= '0;
      g        <= '0;
      eflag    <= 1'b0;
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= '0;
      err      <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
`ifdef TRIG_ARB_CACHE_EN
      cv       <= '0;
      ca       <= '0;
`endif
    end else begin
      state    <= state_nx;
      rr       <= rr_nx;
      g        <= g_nx;
      eflag    <= eflag_nx;
      rom_addr <= addr_nx;
      rom_rd   <= rd_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      sin_q    <= sin_nx;
      cos_q    <= cos_nx;
`ifdef TRIG_ARB_CACHE_EN
      cv       <= cv_nx;
      ca       <= ca_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    g_nx     = g;
    eflag_nx = eflag;
    addr_nx  = rom_addr;
    rd_nx    = 1'b0;
    done_nx  = '0;
    err_nx   = err;
    sin_nx   = sin_q;
    cos_nx   = cos_q;
`ifdef TRIG_ARB_CACHE_EN
    cv_nx    = cv;
    ca_nx    = ca;
`endif

    // The requester whose done is showing is masked so a held req is not
    // re-granted in its own done cycle.
    elig  = req & ~done;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
    ang = angle_in[win*ANG_W +: ANG_W];
    bad = ang > AMAX;

    unique case (state)
      IDLE: begin
        if (found) begin
`ifdef TRIG_ARB_CACHE_EN
          if (!bad && cv[win] && ca[win] == ang) begin
            // Hit: held result is already correct, answer next cycle.
            done_nx[win] = 1'b1;
            err_nx[win]  = 1'b0;
            rr_nx        = nxt(win);
          end else
`endif
          begin
            addr_nx  = bad ? '0 : ang;
            rd_nx    = 1'b1;
            g_nx     = win;
            eflag_nx = bad;
            state_nx = ADDR;
          end
        end
      end
      ADDR: state_nx = DATA;
      DATA: begin
        sin_nx[g]  = rom_sin;
        cos_nx[g]  = rom_cos;
        err_nx[g]  = eflag;
        done_nx[g] = 1'b1;
        rr_nx      = nxt(g);
        state_nx   = IDLE;
`ifdef TRIG_ARB_CACHE_EN
        if (!eflag) begin
          cv_nx[g] = 1'b1;
          ca_nx[g] = rom_addr;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end
endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Self-checking bench for trig_lut_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model of the arbiter.
module tb_trig_lut_arbiter;
  localparam int N = 4;
`ifdef TRIG_ARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*6-1:0] angle_in = '0;
  logic [N-1:0]  done, err;
  logic [N*8-1:0] sin_out, cos_out;
  logic          rom_rd, busy;
  logic [5:0]    rom_addr;
  logic [7:0]    rom_sin = '0, rom_cos = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sin_tab [64];
  logic [7:0] cos_tab [64];

  trig_lut_arbiter #(.N_REQ(N), .ANG_W(6), .ANG_MAX(44)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .angle_in(angle_in),
    .done(done), .err(err), .sin_out(sin_out), .cos_out(cos_out),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_sin(rom_sin),
    .rom_cos(rom_cos), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data appears the cycle after a read strobe.
  always @(posedge Clk) begin
    if (rom_rd) begin
      rom_sin <= sin_tab[rom_addr];
      rom_cos <= cos_tab[rom_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req = '0;
    tick();
    Reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int         m_stage;   // 0 idle, 1 strobe showing, 2 waiting for data
  int         m_g, m_addr, m_rr;
  bit         m_eflag, m_rd, m_busy;
  logic [N-1:0] m_done, m_err;
  logic [7:0] m_sin [N];
  logic [7:0] m_cos [N];
  bit         m_cv [N];
  int         m_ca [N];

  task automatic model_reset();
    m_stage = 0; m_g = 0; m_addr = 0; m_rr = 0;
    m_eflag = 0; m_rd = 0; m_busy = 0; m_done = '0; m_err = '0;
    for (int i = 0; i < N; i++) begin
      m_sin[i] = '0; m_cos[i] = '0; m_cv[i] = 0; m_ca[i] = 0;
    end
  endtask

  // Advance the model by one clock given the inputs presented this cycle.
  task automatic model_step(input logic [N-1:0] rq, input logic [N*6-1:0] ang);
    logic [N-1:0] nd;
    logic [N-1:0] elig;
    nd = '0;
    elig = rq & ~m_done;
    m_rd = 0;
    if (m_stage == 1) begin
      m_stage = 2;
    end else if (m_stage == 2) begin
      m_stage = 0;
      m_sin[m_g] = sin_tab[m_addr];
      m_cos[m_g] = cos_tab[m_addr];
      m_err[m_g] = m_eflag;
      nd[m_g] = 1'b1;
      m_rr = (m_g + 1) % N;
      if (CACHE && !m_eflag) begin
        m_cv[m_g] = 1; m_ca[m_g] = m_addr;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        int a;
        i = (m_rr + k) % N;
        if (elig[i]) begin
          a = int'(ang[i*6 +: 6]);
          if (CACHE && a <= 44 && m_cv[i] && m_ca[i] == a) begin
            nd[i] = 1'b1;
            m_err[i] = 1'b0;
            m_rr = (i + 1) % N;
          end else begin
            m_addr = (a > 44) ? 0 : a;
            m_eflag = (a > 44);
            m_g = i;
            m_rd = 1;
            m_stage = 1;
          end
          break;
        end
      end
    end
    m_done = nd;
    m_busy = (m_stage != 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1;
    req = '0;
    angle_in = '0;
    tick(); tick();
    n_cmp++;
    if ({done, err, rom_rd, busy, rom_addr, sin_out, cos_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got done=%b err=%b rd=%b busy=%b addr=%0d sin=%h cos=%h, want all 0",
               done, err, rom_rd, busy, rom_addr, sin_out, cos_out);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    angle_in[5:0] = 6'd10;
    req = 4'b0001;
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr, busy, done} !== {1'b1, 6'd10, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL single_t1: got rd=%b addr=%0d busy=%b done=%b, want rd=1 addr=10 busy=1 done=0000",
               rom_rd, rom_addr, busy, done);
    end
    tick();
    n_cmp++;
    if ({rom_rd, busy, done} !== {1'b0, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL single_t2: got rd=%b busy=%b done=%b, want rd=0 busy=1 done=0000", rom_rd, busy, done);
    end
    tick();
    n_cmp++;
    if ({done, busy, sin_out[7:0], cos_out[7:0]} !== {4'b0001, 1'b0, 8'h4E, 8'h3C}) begin
      n_err++;
      $display("FAIL single_t3: got done=%b busy=%b sin=%h cos=%h, want done=0001 busy=0 sin=4e cos=3c",
               done, busy, sin_out[7:0], cos_out[7:0]);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) angle_in[i*6 +: 6] = 6'(11 * i);
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      tick();
      n_cmp++;
      if ({rom_rd, rom_addr} !== {1'b1, 6'(11 * k)}) begin
        n_err++;
        $display("FAIL rr_addr%0d: got rd=%b addr=%0d, want rd=1 addr=%0d", k, rom_rd, rom_addr, 11 * k);
      end
      tick(); tick();
      n_cmp++;
      if (done !== 4'(1 << k)) begin
        n_err++;
        $display("FAIL rr_done%0d: got done=%b, want %b", k, done, 4'(1 << k));
      end
      req[k] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if ({sin_out[i*8 +: 8], cos_out[i*8 +: 8]} !== {sin_tab[11*i], cos_tab[11*i]}) begin
        n_err++;
        $display("FAIL rr_data%0d: got sin=%h cos=%h, want sin=%h cos=%h",
                 i, sin_out[i*8 +: 8], cos_out[i*8 +: 8], sin_tab[11*i], cos_tab[11*i]);
      end
    end
    tick();
  endtask

  task automatic test_out_of_range();
    angle_in[17:12] = 6'd50;
    req = 4'b0100;
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr} !== {1'b1, 6'd0}) begin
      n_err++;
      $display("FAIL oor_addr: got rd=%b addr=%0d, want rd=1 addr=0", rom_rd, rom_addr);
    end
    tick(); tick();
    n_cmp++;
    if ({done, err, sin_out[23:16]} !== {4'b0100, 4'b0100, sin_tab[0]}) begin
      n_err++;
      $display("FAIL oor_done: got done=%b err=%b sin2=%h, want done=0100 err=0100 sin2=%h",
               done, err, sin_out[23:16], sin_tab[0]);
    end
    req = '0;
    tick();
    n_cmp++;
    if (err !== 4'b0100) begin
      n_err++;
      $display("FAIL oor_hold: got err=%b, want 0100", err);
    end
    angle_in[17:12] = 6'd5;
    req = 4'b0100;
    tick(); tick();
    n_cmp++;
    if (err !== 4'b0100) begin
      n_err++;
      $display("FAIL oor_midhold: got err=%b, want 0100", err);
    end
    tick();
    n_cmp++;
    if ({done, err, sin_out[23:16]} !== {4'b0100, 4'b0000, sin_tab[5]}) begin
      n_err++;
      $display("FAIL oor_clear: got done=%b err=%b sin2=%h, want done=0100 err=0000 sin2=%h",
               done, err, sin_out[23:16], sin_tab[5]);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    // rr is 3 here, so a grant to requester 1 after reset proves rr was cleared.
    angle_in[11:6]  = 6'd20;
    angle_in[23:18] = 6'd30;
    req = 4'b0010;
    tick();
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({done, err, rom_rd, busy, rom_addr, sin_out, cos_out} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outs: got done=%b err=%b rd=%b busy=%b addr=%0d sin=%h cos=%h, want all 0",
               done, err, rom_rd, busy, rom_addr, sin_out, cos_out);
    end
    req = '0;
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({done, rom_rd, busy} !== '0) begin
        n_err++;
        $display("FAIL rstmid_quiet%0d: got done=%b rd=%b busy=%b, want all 0", c, done, rom_rd, busy);
      end
    end
    req = 4'b1010;
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr} !== {1'b1, 6'd20}) begin
      n_err++;
      $display("FAIL rstmid_rr0: got rd=%b addr=%0d, want rd=1 addr=20", rom_rd, rom_addr);
    end
    req = 4'b0000;
    tick(); tick();
    n_cmp++;
    if (done !== 4'b0010) begin
      n_err++;
      $display("FAIL rstmid_done: got done=%b, want 0010", done);
    end
    tick();
  endtask

  task automatic test_hold_past_done();
    do_reset();
    angle_in[11:6] = 6'd20;
    req = 4'b0010;
    tick(); tick(); tick();
    n_cmp++;
    if (done !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_done1: got done=%b, want 0010", done);
    end
    tick();
    n_cmp++;
    if ({rom_rd, busy, done} !== {1'b0, 1'b0, 4'b0000}) begin
      n_err++;
      $display("FAIL hold_masked: got rd=%b busy=%b done=%b, want rd=0 busy=0 done=0000", rom_rd, busy, done);
    end
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr} !== {1'b1, 6'd20}) begin
      n_err++;
      $display("FAIL hold_regrant: got rd=%b addr=%0d, want rd=1 addr=20", rom_rd, rom_addr);
    end
    req = '0;   // dropped mid-lookup: done must still pulse
    tick(); tick();
    n_cmp++;
    if (done !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_dropdone: got done=%b, want 0010", done);
    end
    tick();
  endtask

`ifdef TRIG_ARB_CACHE_EN
  task automatic test_cache();
    do_reset();
    angle_in[5:0] = 6'd7;
    req = 4'b0001;
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr} !== {1'b1, 6'd7}) begin
      n_err++;
      $display("FAIL cache_miss_rd: got rd=%b addr=%0d, want rd=1 addr=7", rom_rd, rom_addr);
    end
    tick(); tick();
    n_cmp++;
    if ({done, sin_out[7:0]} !== {4'b0001, sin_tab[7]}) begin
      n_err++;
      $display("FAIL cache_miss_done: got done=%b sin=%h, want done=0001 sin=%h", done, sin_out[7:0], sin_tab[7]);
    end
    req = '0;
    tick();
    req = 4'b0001;
    tick();
    n_cmp++;
    if ({done, rom_rd, busy, sin_out[7:0], cos_out[7:0]} !== {4'b0001, 1'b0, 1'b0, sin_tab[7], cos_tab[7]}) begin
      n_err++;
      $display("FAIL cache_hit: got done=%b rd=%b busy=%b sin=%h cos=%h, want done=0001 rd=0 busy=0 sin=%h cos=%h",
               done, rom_rd, busy, sin_out[7:0], cos_out[7:0], sin_tab[7], cos_tab[7]);
    end
    req = '0;
    tick();
    angle_in[5:0] = 6'd8;
    req = 4'b0001;
    tick();
    n_cmp++;
    if ({rom_rd, rom_addr, done} !== {1'b1, 6'd8, 4'b0000}) begin
      n_err++;
      $display("FAIL cache_miss8: got rd=%b addr=%0d done=%b, want rd=1 addr=8 done=0000", rom_rd, rom_addr, done);
    end
    tick(); tick();
    n_cmp++;
    if ({done, sin_out[7:0]} !== {4'b0001, sin_tab[8]}) begin
      n_err++;
      $display("FAIL cache_done8: got done=%b sin=%h, want done=0001 sin=%h", done, sin_out[7:0], sin_tab[8]);
    end
    req = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [N*8-1:0] e_sin, e_cos;
    do_reset();
    angle_in = '0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            int r;
            r = int'($urandom_range(0, 9));
            angle_in[i*6 +: 6] = (r < 8) ? 6'(r * 5) : 6'($urandom_range(45, 63));
            req[i] = 1'b1;
          end
        end else if (m_done[i] && $urandom_range(0, 1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      model_step(req, angle_in);
      tick();
      for (int i = 0; i < N; i++) begin
        e_sin[i*8 +: 8] = m_sin[i];
        e_cos[i*8 +: 8] = m_cos[i];
      end
      n_cmp++;
      if ({done, err, rom_rd, busy} !== {m_done, m_err, m_rd, m_busy}) begin
        n_err++;
        $display("FAIL rand_ctl c=%0d: got done=%b err=%b rd=%b busy=%b, want done=%b err=%b rd=%b busy=%b",
                 c, done, err, rom_rd, busy, m_done, m_err, m_rd, m_busy);
      end
      n_cmp++;
      if ({sin_out, cos_out} !== {e_sin, e_cos}) begin
        n_err++;
        $display("FAIL rand_data c=%0d: got sin=%h cos=%h, want sin=%h cos=%h", c, sin_out, cos_out, e_sin, e_cos);
      end
      if (m_rd) begin
        n_cmp++;
        if (rom_addr !== 6'(m_addr)) begin
          n_err++;
          $display("FAIL rand_addr c=%0d: got addr=%0d, want %0d", c, rom_addr, m_addr);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin
      sin_tab[a] = 8'((a * 37 + 5) & 8'hFF);
      cos_tab[a] = 8'((a * 91 + 200) & 8'hFF);
    end
    sin_tab[10] = 8'h4E;
    cos_tab[10] = 8'h3C;

    test_reset();
    test_single();
    test_round_robin();
    test_out_of_range();
    test_reset_mid();
    test_hold_past_done();
`ifdef TRIG_ARB_CACHE_EN
    test_cache();
`endif
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
